winograd1d: RTL and testbench
=============================

WINOGRAD1D -- requirements
Module: winograd1d

Interface
REQ-001 Parameter ERROR_CORRECTION, default 0: 0 selects the truncating filter transform, 1 selects the exact (error-corrected) datapath.
REQ-002 Parameter W, default 32: width of data, weight and result ports.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  qualifies r1_x..r4_x and r1_w..r3_w in the current cycle.
REQ-007 r1_x, r2_x, r3_x, r4_x  input  W each  signed input tile d0..d3.
REQ-008 r1_w, r2_w, r3_w  input  W each  signed 3-tap filter g0..g2.
REQ-009 r1_res, r2_res  output  W each  signed results y0, y1.
REQ-010 out_valid  output  1  high when r1_res and r2_res carry a new result.
REQ-011 winograd1d_error_correction SHALL be a port-identical wrapper instantiating winograd1d with ERROR_CORRECTION=1.

Function
REQ-012 The block SHALL compute Winograd F(2,3): exact target y0=d0*g0+d1*g1+d2*g2, y1=d1*g0+d2*g1+d3*g2.
REQ-013 Stage 1 SHALL register the input transforms a1=d0-d2, a2=d1+d2, a3=d2-d1, a4=d1-d3, each W+1 bits signed.
REQ-014 Stage 1 SHALL register the filter transforms b1=g0 and b4=g2, plus s=g0+g1+g2 and t=g0-g1+g2, each W+2 bits signed.
REQ-015 ERROR_CORRECTION=0: b2=s>>>1 and b3=t>>>1, using arithmetic shift (floor).
REQ-016 ERROR_CORRECTION=1: b1=2*g0, b2=s, b3=t and b4=2*g2, with no division.
REQ-017 Stage 2 SHALL register the products mk=ak*bk for k=1..4, each full-precision signed (2W+3 bits).
REQ-018 Stage 3 SHALL register p0=m1+m2+m3 and p1=m2-m3-m4 at full precision (2W+5 bits).
REQ-019 ERROR_CORRECTION=1: the results SHALL be p0>>>1 and p1>>>1; p0 and p1 are always even, so the result is exact.
REQ-020 ERROR_CORRECTION=0: the results SHALL be p0 and p1 directly, and may differ from the exact value when s or t is odd.
REQ-021 The outputs SHALL be the low W bits of the stage-3 result (two's-complement wrap), with no saturation.
REQ-022 Latency: a result for inputs sampled at edge N SHALL appear, with out_valid high, after edge N+3.
REQ-023 Throughput SHALL be one tile per cycle, with no stalls and no backpressure.
REQ-024 A valid bit SHALL travel with each stage; a stage register SHALL load only when its incoming valid bit is high and otherwise hold.
REQ-025 r1_res and r2_res SHALL hold their last value while out_valid is low.
REQ-026 Back-to-back valid inputs SHALL produce back-to-back valid outputs in input order.
REQ-027 X or undriven inputs while in_valid=0 SHALL NOT disturb held outputs.

Reset
REQ-028 While rst is high, all stage registers, all valid bits, r1_res, r2_res and out_valid SHALL be 0, immediately and independently of clk.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight tiles; no out_valid SHALL follow from tiles accepted before the reset.
REQ-030 After rst deasserts, the first valid input SHALL be accepted on the next rising edge.

Verification
REQ-031 Inputs x=(3,1,0,3), w=(0,1,2), in_valid pulse: ERROR_CORRECTION=1 -> (1,6) three cycles later; ERROR_CORRECTION=0 -> (1,5).
REQ-032 Inputs x=(2,0,-1,2), w=(2,3,6): ERROR_CORRECTION=1 -> (-2,9); ERROR_CORRECTION=0 -> (-1,9).
REQ-033 Stream the sequence x-=1 per element and w+=(2,2,4) per cycle, starting from REQ-031, for 20 consecutive cycles -> the ERROR_CORRECTION=1 outputs match the exact dot products every cycle with out_valid continuously high.
REQ-034 Assert rst while 2 tiles are in flight -> outputs 0 and out_valid 0 at once; no stale out_valid after release.
REQ-035 Extremes x=(0x7FFFFFFF,0x80000000,0x7FFFFFFF,0x80000000), w=(0x7FFFFFFF,0x80000000,0x7FFFFFFF) -> outputs equal the low 32 bits of the exact 64-bit-plus results (ERROR_CORRECTION=1).
REQ-036 in_valid low for 5 cycles after a result -> r1_res and r2_res hold and out_valid stays 0.

Source files
------------

// File: rtl/winograd1d.sv
// Winograd F(2,3) 1-D convolution tile: four-register pipeline (transform, multiply, combine, result).
// ERROR_CORRECTION selects the halved (truncating) filter transform or the exact doubled-filter datapath.
module winograd1d #(
    parameter int ERROR_CORRECTION = 0,
    parameter int W                = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] r1_x,
    input  logic [W-1:0] r2_x,
    input  logic [W-1:0] r3_x,
    input  logic [W-1:0] r4_x,
    input  logic [W-1:0] r1_w,
    input  logic [W-1:0] r2_w,
    input  logic [W-1:0] r3_w,
    output logic [W-1:0] r1_res,
    output logic [W-1:0] r2_res,
    output logic         out_valid
);
    localparam int AW = W + 1;
    localparam int BW = W + 2;
    localparam int MW = 2 * W + 3;
    localparam int PW = 2 * W + 5;

    logic signed [AW-1:0] d0, d1, d2, d3;
    logic signed [BW-1:0] g0, g1, g2, s_next, t_next;
    logic signed [BW-1:0] b1_next, b2_next, b3_next, b4_next;

    assign d0 = {r1_x[W-1], r1_x};
    assign d1 = {r2_x[W-1], r2_x};
    assign d2 = {r3_x[W-1], r3_x};
    assign d3 = {r4_x[W-1], r4_x};
    assign g0 = {{2{r1_w[W-1]}}, r1_w};
    assign g1 = {{2{r2_w[W-1]}}, r2_w};
    assign g2 = {{2{r3_w[W-1]}}, r3_w};
    assign s_next = g0 + g1 + g2;
    assign t_next = g0 - g1 + g2;

    logic                 v1_reg, v2_reg, v3_reg, out_valid_reg;
    logic signed [AW-1:0] a1_reg, a2_reg, a3_reg, a4_reg;
    logic signed [BW-1:0] b1_reg, b2_reg, b3_reg, b4_reg;
    logic signed [MW-1:0] m1_reg, m2_reg, m3_reg, m4_reg;
    logic signed [PW-1:0] p0_reg, p1_reg;
    logic [W-1:0]         r1_res_reg, r2_res_reg;
    logic [W-1:0]         y0_next, y1_next;
    logic                 unused_bits;

    // Exact mode doubles every filter term instead of halving two of them, then halves the final sums.
    generate
        if (ERROR_CORRECTION != 0) begin : g_exact
            assign b1_next     = g0 <<< 1;
            assign b2_next     = s_next;
            assign b3_next     = t_next;
            assign b4_next     = g2 <<< 1;
            assign y0_next     = p0_reg[W:1];
            assign y1_next     = p1_reg[W:1];
            assign unused_bits = ^{p0_reg[PW-1:W+1], p0_reg[0], p1_reg[PW-1:W+1], p1_reg[0]};
        end else begin : g_trunc
            assign b1_next     = g0;
            assign b2_next     = s_next >>> 1;
            assign b3_next     = t_next >>> 1;
            assign b4_next     = g2;
            assign y0_next     = p0_reg[W-1:0];
            assign y1_next     = p1_reg[W-1:0];
            assign unused_bits = ^{p0_reg[PW-1:W], p1_reg[PW-1:W]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            v3_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            a1_reg <= '0; a2_reg <= '0; a3_reg <= '0; a4_reg <= '0;
            b1_reg <= '0; b2_reg <= '0; b3_reg <= '0; b4_reg <= '0;
            m1_reg <= '0; m2_reg <= '0; m3_reg <= '0; m4_reg <= '0;
            p0_reg <= '0; p1_reg <= '0;
            r1_res_reg <= '0;
            r2_res_reg <= '0;
        end else begin
            v1_reg        <= in_valid;
            v2_reg        <= v1_reg;
            v3_reg        <= v2_reg;
            out_valid_reg <= v3_reg;
            // Each stage only loads behind its own valid bit, so idle inputs never reach the outputs.
            if (in_valid) begin
                a1_reg <= d0 - d2;
                a2_reg <= d1 + d2;
                a3_reg <= d2 - d1;
                a4_reg <= d1 - d3;
                b1_reg <= b1_next;
                b2_reg <= b2_next;
                b3_reg <= b3_next;
                b4_reg <= b4_next;
            end
            if (v1_reg) begin
                m1_reg <= a1_reg * b1_reg;
                m2_reg <= a2_reg * b2_reg;
                m3_reg <= a3_reg * b3_reg;
                m4_reg <= a4_reg * b4_reg;
            end
            if (v2_reg) begin
                p0_reg <= m1_reg + m2_reg + m3_reg;
                p1_reg <= m2_reg - m3_reg - m4_reg;
            end
            if (v3_reg) begin
                r1_res_reg <= y0_next;
                r2_res_reg <= y1_next;
            end
        end
    end

    assign r1_res    = r1_res_reg;
    assign r2_res    = r2_res_reg;
    assign out_valid = out_valid_reg;
endmodule

module winograd1d_error_correction #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] r1_x,
    input  logic [W-1:0] r2_x,
    input  logic [W-1:0] r3_x,
    input  logic [W-1:0] r4_x,
    input  logic [W-1:0] r1_w,
    input  logic [W-1:0] r2_w,
    input  logic [W-1:0] r3_w,
    output logic [W-1:0] r1_res,
    output logic [W-1:0] r2_res,
    output logic         out_valid
);
    winograd1d #(.ERROR_CORRECTION(1), .W(W)) u_core (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .r1_x(r1_x), .r2_x(r2_x), .r3_x(r3_x), .r4_x(r4_x),
        .r1_w(r1_w), .r2_w(r2_w), .r3_w(r3_w),
        .r1_res(r1_res), .r2_res(r2_res), .out_valid(out_valid)
    );
endmodule

// File: tb/tb_winograd1d.sv
// Bench for winograd1d: truncating and exact instances side by side, checked against a dot-product model.
module tb_winograd1d;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] r1_x = '0, r2_x = '0, r3_x = '0, r4_x = '0;
    logic [W-1:0] r1_w = '0, r2_w = '0, r3_w = '0;
    logic [W-1:0] ec_r1, ec_r2, tr_r1, tr_r2;
    logic         ec_ov, tr_ov;

    always #5 clk = ~clk;

    winograd1d #(.ERROR_CORRECTION(1), .W(W)) u_ec (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .r1_x(r1_x), .r2_x(r2_x), .r3_x(r3_x), .r4_x(r4_x),
        .r1_w(r1_w), .r2_w(r2_w), .r3_w(r3_w),
        .r1_res(ec_r1), .r2_res(ec_r2), .out_valid(ec_ov)
    );

    winograd1d #(.ERROR_CORRECTION(0), .W(W)) u_tr (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .r1_x(r1_x), .r2_x(r2_x), .r3_x(r3_x), .r4_x(r4_x),
        .r1_w(r1_w), .r2_w(r2_w), .r3_w(r3_w),
        .r1_res(tr_r1), .r2_res(tr_r2), .out_valid(tr_ov)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [31:0] e0, e1, t0, t1;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic        mon_hit;
    logic [31:0] held_e0 = '0, held_e1 = '0, held_t0 = '0, held_t1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Exact result is the plain dot product; truncated result uses the floor-halved filter sums.
    function automatic exp_t model(input int due, input logic [31:0] a, b, c, d, e, f, g);
        exp_t   r;
        longint x0, x1, x2, x3, w0, w1, w2, s, t, m1, m2, m3, m4, y0, y1;
        x0 = longint'($signed(a)); x1 = longint'($signed(b));
        x2 = longint'($signed(c)); x3 = longint'($signed(d));
        w0 = longint'($signed(e)); w1 = longint'($signed(f)); w2 = longint'($signed(g));
        y0 = x0 * w0 + x1 * w1 + x2 * w2;
        y1 = x1 * w0 + x2 * w1 + x3 * w2;
        r.e0 = y0[31:0];
        r.e1 = y1[31:0];
        s  = (w0 + w1 + w2) >>> 1;
        t  = (w0 - w1 + w2) >>> 1;
        m1 = (x0 - x2) * w0;
        m2 = (x1 + x2) * s;
        m3 = (x2 - x1) * t;
        m4 = (x1 - x3) * w2;
        y0 = m1 + m2 + m3;
        y1 = m2 - m3 - m4;
        r.t0 = y0[31:0];
        r.t1 = y1[31:0];
        r.due = due;
        return r;
    endfunction

    task automatic send(input logic [31:0] a, b, c, d, e, f, g);
        r1_x = a; r2_x = b; r3_x = c; r4_x = d;
        r1_w = e; r2_w = f; r3_w = g;
        in_valid = 1'b1;
        q.push_back(model(cyc + 4, a, b, c, d, e, f, g));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            r1_x = 'x; r2_x = 'x; r3_x = 'x; r4_x = 'x;
            r1_w = 'x; r2_w = 'x; r3_w = 'x;
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rv();
        logic [31:0] v;
        if ($urandom_range(1) == 0) v = $urandom;
        else                        v = 32'($urandom_range(40)) - 32'd20;
        return v;
    endfunction

    // Every cycle: out_valid must match the scoreboard; results match on a tile, otherwise hold.
    always @(negedge clk) begin
        if (!rst) begin
            mon_hit = (q.size() > 0) && (q[0].due == cyc);
            check("ec_valid", ec_ov, mon_hit);
            check("tr_valid", tr_ov, mon_hit);
            if (mon_hit) begin
                mon_e = q.pop_front();
                check("ec_y0", ec_r1, mon_e.e0);
                check("ec_y1", ec_r2, mon_e.e1);
                check("tr_y0", tr_r1, mon_e.t0);
                check("tr_y1", tr_r2, mon_e.t1);
                held_e0 = mon_e.e0; held_e1 = mon_e.e1;
                held_t0 = mon_e.t0; held_t1 = mon_e.t1;
                $display("tile cycle %0d: ec=(%0d,%0d) tr=(%0d,%0d)", cyc,
                         $signed(ec_r1), $signed(ec_r2), $signed(tr_r1), $signed(tr_r2));
            end else begin
                check("ec_hold0", ec_r1, held_e0);
                check("ec_hold1", ec_r2, held_e1);
                check("tr_hold0", tr_r1, held_t0);
                check("tr_hold1", tr_r2, held_t1);
            end
        end
    end

    initial begin
        logic [31:0] xa, xb, xc, xd, wa, wb, wc;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ec_r1", ec_r1, 0);
        check("rst_ec_r2", ec_r2, 0);
        check("rst_ec_ov", ec_ov, 0);
        check("rst_tr_ov", tr_ov, 0);
        rst = 1'b0;

        // Two worked examples with the documented answers.
        send(32'd3, 32'd1, 32'd0, 32'd3, 32'd0, 32'd1, 32'd2);
        idle(3);
        check("ex1_ov", ec_ov, 1);
        check("ex1_ec0", ec_r1, 32'd1);
        check("ex1_ec1", ec_r2, 32'd6);
        check("ex1_tr0", tr_r1, 32'd1);
        check("ex1_tr1", tr_r2, 32'd5);
        send(32'd2, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd3, 32'd6);
        idle(3);
        check("ex2_ec0", ec_r1, 32'hFFFF_FFFE);
        check("ex2_ec1", ec_r2, 32'd9);
        check("ex2_tr0", tr_r1, 32'hFFFF_FFFF);
        check("ex2_tr1", tr_r2, 32'd9);
        idle(2);

        // Back-to-back stream of 20 tiles.
        xa = 32'd3; xb = 32'd1; xc = 32'd0; xd = 32'd3;
        wa = 32'd0; wb = 32'd1; wc = 32'd2;
        for (int i = 0; i < 20; i++) begin
            send(xa, xb, xc, xd, wa, wb, wc);
            xa -= 1; xb -= 1; xc -= 1; xd -= 1;
            wa += 2; wb += 2; wc += 4;
        end
        idle(4);

        // Extreme operands, then a long idle gap where outputs must hold.
        send(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
             32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);
        idle(4);
        idle(5);

        // Reset with two tiles in flight.
        send(32'd5, 32'd6, 32'd7, 32'd8, 32'd1, 32'd2, 32'd3);
        send(32'd9, 32'd4, 32'd2, 32'd1, 32'd3, 32'd3, 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_ec_r1", ec_r1, 0);
        check("mid_rst_ec_r2", ec_r2, 0);
        check("mid_rst_ec_ov", ec_ov, 0);
        check("mid_rst_tr_r1", tr_r1, 0);
        check("mid_rst_tr_ov", tr_ov, 0);
        q.delete();
        held_e0 = '0; held_e1 = '0; held_t0 = '0; held_t1 = '0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);

        // Accepted on the first edge after release, then randomized traffic with gaps.
        send(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) idle(1);
            else send(rv(), rv(), rv(), rv(), rv(), rv(), rv());
        end
        idle(6);
        check("drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
